// File: rtl/pipe_mux_reg.sv
// N-way operand-select mux into a stall/flush pipeline register with a valid bit and a sticky bad-select flag.
// Optional build macro: PIPE_MUX_HOLD_INVALID_EN (keep data/tag on bubble captures).
module pipe_mux_reg #(
  parameter int                     VALUE_WIDTH = 32,
  parameter int                     NUM_INPUTS  = 4,
  parameter logic [VALUE_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                    SEL_WIDTH   = $clog2(NUM_INPUTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stall,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [SEL_WIDTH-1:0]              sel,
  input  logic [NUM_INPUTS*VALUE_WIDTH-1:0] in_flat,
  output logic [VALUE_WIDTH-1:0]            out,
  output logic                              out_valid,
  output logic [SEL_WIDTH-1:0]              out_sel,
  output logic                              sel_err
);

  logic [VALUE_WIDTH-1:0] mux_data;
  logic                   sel_ok;

  logic [VALUE_WIDTH-1:0] out_d,       out_q;
  logic                   out_valid_d, out_valid_q;
  logic [SEL_WIDTH-1:0]   out_sel_d,   out_sel_q;
  logic                   sel_err_d,   sel_err_q;

  // Decode by equality so unused codes (non power-of-two counts) fall through to zero.
  always_comb begin
    mux_data = '0;
    sel_ok   = 1'b0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        mux_data = in_flat[i*VALUE_WIDTH +: VALUE_WIDTH];
        sel_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    sel_err_d   = sel_err_q;
    if (flush) begin
      out_d       = RESET_VALUE;
      out_valid_d = 1'b0;
      out_sel_d   = '0;
    end else if (!stall) begin
      out_valid_d = in_valid;
      if (in_valid && !sel_ok) sel_err_d = 1'b1;
`ifdef PIPE_MUX_HOLD_INVALID_EN
      if (in_valid) begin
        out_d     = mux_data;
        out_sel_d = sel;
      end
`else
      out_d     = mux_data;
      out_sel_d = sel;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= RESET_VALUE;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_sel   = out_sel_q;
  assign sel_err   = sel_err_q;

endmodule
